sincpde_window: RTL and testbench

- Front-end capture stage that sits directly upstream of the sincpde_single_dfs delay/amplitude estimator.
- Watches a continuous 18-bit ADC sample stream and detects pulse peaks.
- For each accepted peak, presents an 11-sample window centred on the peak (sample5 = peak) together with a one-cycle sync_out. That sync_out drives the estimator's sync_in.
- Enforces a holdoff between windows and counts peaks dropped during holdoff.

---
 rtl/sincpde_window.sv | 142 ++++++++++++++
 tb/tb_sincpde_window.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sincpde_window.sv
// Peak-triggered 11-sample window capture ahead of the sincpde_single_dfs estimator.
// Optional `SINCPDE_WINDOW_BASELINE_EN: subtract (first+last)/2 from the window on load.
module sincpde_window #(
  parameter int WIDTH   = 18,
  parameter int THRESH  = 1000,
  parameter int HOLDOFF = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adc_valid,
  input  logic [WIDTH-1:0] adc_data,
  output logic             sync_out,
  output logic [WIDTH-1:0] sample0,
  output logic [WIDTH-1:0] sample1,
  output logic [WIDTH-1:0] sample2,
  output logic [WIDTH-1:0] sample3,
  output logic [WIDTH-1:0] sample4,
  output logic [WIDTH-1:0] sample5,
  output logic [WIDTH-1:0] sample6,
  output logic [WIDTH-1:0] sample7,
  output logic [WIDTH-1:0] sample8,
  output logic [WIDTH-1:0] sample9,
  output logic [WIDTH-1:0] sample10,
  output logic             busy,
  output logic [15:0]      drop_cnt
);

  localparam int CW = $clog2(HOLDOFF + 2);

  typedef enum logic [1:0] {FILL, ARMED, HOLD} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr      [0:10];
  logic [WIDTH-1:0] sr_nxt  [0:10];
  logic [WIDTH-1:0] win     [0:10];
  logic [WIDTH-1:0] win_nxt [0:10];
  logic [3:0]       fill_cnt, fill_cnt_nxt;
  logic [CW-1:0]    hold_cnt, hold_cnt_nxt;
  logic             peak_now, peak_flag, peak_flag_nxt;
  logic             accept, drop;

  always_comb begin
    for (int k = 0; k < 10; k++) sr_nxt[k] = adc_valid ? sr[k+1] : sr[k];
    sr_nxt[10] = adc_valid ? adc_data : sr[10];
  end

  // Strict rise / non-strict fall: on a flat top only the oldest equal sample qualifies.
  assign peak_now = (sr_nxt[5] >= WIDTH'(THRESH)) && (sr_nxt[5] > sr_nxt[4]) &&
                    (sr_nxt[5] >= sr_nxt[6]);
  assign peak_flag_nxt = adc_valid && peak_now && ((state != FILL) || (fill_cnt == 4'd10));

`ifdef SINCPDE_WINDOW_BASELINE_EN
  logic [WIDTH:0]   base_sum;
  logic [WIDTH-1:0] base;
  assign base_sum = {1'b0, sr[0]} + {1'b0, sr[10]};
  assign base     = base_sum[WIDTH:1];
  always_comb begin
    for (int k = 0; k < 11; k++) win_nxt[k] = (sr[k] > base) ? (sr[k] - base) : '0;
  end
`else
  always_comb begin
    for (int k = 0; k < 11; k++) win_nxt[k] = sr[k];
  end
`endif

  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    hold_cnt_nxt = hold_cnt;
    accept       = 1'b0;
    drop         = 1'b0;
    case (state)
      FILL: begin
        if (adc_valid) begin
          if (fill_cnt == 4'd10) state_nxt = ARMED;
          else                   fill_cnt_nxt = fill_cnt + 4'd1;
        end
      end
      ARMED: begin
        if (peak_flag) begin
          accept    = 1'b1;
          state_nxt = HOLD;
          // A sample arriving on the load edge is not counted, so a gap here must add one
          // to keep the holdoff measured in samples after the peak regardless of gaps.
          hold_cnt_nxt = adc_valid ? CW'(HOLDOFF) : CW'(HOLDOFF + 1);
        end
      end
      HOLD: begin
        drop = peak_flag;
        if (adc_valid) begin
          if (hold_cnt <= CW'(1)) begin
            state_nxt    = ARMED;
            hold_cnt_nxt = '0;
          end else begin
            hold_cnt_nxt = hold_cnt - CW'(1);
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      fill_cnt  <= '0;
      hold_cnt  <= '0;
      peak_flag <= 1'b0;
      sync_out  <= 1'b0;
      drop_cnt  <= '0;
      for (int k = 0; k < 11; k++) begin
        sr[k]  <= '0;
        win[k] <= '0;
      end
    end else begin
      state     <= state_nxt;
      fill_cnt  <= fill_cnt_nxt;
      hold_cnt  <= hold_cnt_nxt;
      peak_flag <= peak_flag_nxt;
      sync_out  <= accept;
      for (int k = 0; k < 11; k++) sr[k] <= sr_nxt[k];
      if (accept) begin
        for (int k = 0; k < 11; k++) win[k] <= win_nxt[k];
      end
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign busy     = (state == HOLD);
  assign sample0  = win[0];
  assign sample1  = win[1];
  assign sample2  = win[2];
  assign sample3  = win[3];
  assign sample4  = win[4];
  assign sample5  = win[5];
  assign sample6  = win[6];
  assign sample7  = win[7];
  assign sample8  = win[8];
  assign sample9  = win[9];
  assign sample10 = win[10];

endmodule

// File: tb/tb_sincpde_window.sv
// Bench for sincpde_window: per-cycle comparison against a sample-index model plus directed literal checks.
module tb_sincpde_window;
  localparam int W  = 18;
  localparam int TH = 1000;
  localparam int HO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic adc_valid = 1'b0;
  logic [W-1:0] adc_data = '0;
  logic sync_out, busy;
  logic [15:0] drop_cnt;
  logic [W-1:0] s0, s1, s2, s3, s4, s5, s6, s7, s8, s9, s10;
  logic [11*W-1:0] dut_win;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sincpde_window #(.WIDTH(W), .THRESH(TH), .HOLDOFF(HO)) dut (
    .clk(clk), .rst(rst), .adc_valid(adc_valid), .adc_data(adc_data),
    .sync_out(sync_out),
    .sample0(s0), .sample1(s1), .sample2(s2), .sample3(s3), .sample4(s4), .sample5(s5),
    .sample6(s6), .sample7(s7), .sample8(s8), .sample9(s9), .sample10(s10),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  assign dut_win = {s10, s9, s8, s7, s6, s5, s4, s3, s2, s1, s0};

  int REFP [11] = '{23, 23, 22, 169, 1697, 2833, 1640, 465, 81, 5, 1};
  int LOWP [11] = '{7, 7, 7, 54, 539, 900, 521, 148, 26, 2, 0};
`ifdef SINCPDE_WINDOW_BASELINE_EN
  int REFW [11] = '{11, 11, 10, 157, 1685, 2821, 1628, 453, 69, 0, 0};
`else
  int REFW [11] = '{23, 23, 22, 169, 1697, 2833, 1640, 465, 81, 5, 1};
`endif
  int TAILP [7] = '{1697, 2833, 1640, 465, 81, 5, 1};

  // Model: index valid samples since reset; a peak at sample n is accepted when no
  // accepted peak lies within the previous HO samples, and appears one edge later.
  int m_n = 0;
  int m_last = -1000;
  int m_hold_end = -1;
  int m_q[$];
  bit m_pend = 0, m_pdrop = 0;
  int m_pwin [11];
  int e_win [11];
  bit e_sync = 0, e_busy = 0;
  int e_drop = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_n = 0; m_last = -1000; m_hold_end = -1; m_q.delete();
      m_pend = 0; m_pdrop = 0; e_sync = 0; e_busy = 0; e_drop = 0;
      for (int k = 0; k < 11; k++) e_win[k] = 0;
    end else begin
      e_sync = m_pend;
      if (m_pend) begin
        e_win = m_pwin;
        e_busy = 1;
      end
      if (m_pdrop && e_drop < 65535) e_drop++;
      m_pend = 0;
      m_pdrop = 0;
      if (adc_valid) begin
        m_n++;
        m_q.push_back(int'(adc_data));
        if (m_q.size() > 11) void'(m_q.pop_front());
        if (m_n == m_hold_end) e_busy = 0;
        if (m_n >= 11 && m_q[5] >= TH && m_q[5] > m_q[4] && m_q[5] >= m_q[6]) begin
          if (m_n - m_last > HO) begin
            int base;
            m_last = m_n;
            m_hold_end = m_n + HO + 1;
            m_pend = 1;
`ifdef SINCPDE_WINDOW_BASELINE_EN
            base = (m_q[0] + m_q[10]) / 2;
`else
            base = 0;
`endif
            for (int k = 0; k < 11; k++) m_pwin[k] = (m_q[k] > base) ? m_q[k] - base : 0;
          end else begin
            m_pdrop = 1;
          end
        end
      end
    end
  end

  int tests = 0, fails = 0;
  int sync_tot = 0, busy_tot = 0, sync_cyc = 0, last_cyc = 0, mark_cyc = 0;

  task automatic chk(input string name, input logic [11*W-1:0] act, input logic [11*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11*W-1:0] pack(input int a [11]);
    logic [11*W-1:0] r;
    for (int k = 0; k < 11; k++) r[k*W +: W] = W'(a[k]);
    return r;
  endfunction

  task automatic send(input int v, input int gap);
    @(negedge clk);
    adc_valid = 1'b1;
    adc_data  = W'(v);
    @(posedge clk);
    #1 last_cyc = cyc;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      adc_valid = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    adc_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) send(0, 0);
  endtask

  task automatic do_reset();
    idle(1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  // Reference pulse at p0, optional second at p1 (overlap resolved by max), 30 zeros after.
  task automatic run_pulses(input int p0, input int p1, input int gap);
    int buf_s [100];
    int len;
    for (int i = 0; i < 100; i++) buf_s[i] = 0;
    for (int k = 0; k < 11; k++) buf_s[p0+k] = REFP[k];
    if (p1 >= 0)
      for (int k = 0; k < 11; k++) if (REFP[k] > buf_s[p1+k]) buf_s[p1+k] = REFP[k];
    len = ((p1 > p0) ? p1 : p0) + 41;
    for (int i = 0; i < len; i++) begin
      send(buf_s[i], gap);
      if (i == p0 + 10) mark_cyc = last_cyc;
    end
    idle(3);
  endtask

  int sb, bb;
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (sync_out) begin
          sync_tot++;
          sync_cyc = cyc;
        end
        if (busy) busy_tot++;
        chk("cyc_sync", sync_out, e_sync);
        chk("cyc_busy", busy, e_busy);
        chk("cyc_drop", drop_cnt, e_drop);
        chk("cyc_win", dut_win, pack(e_win));
      end
      begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "timeout");
      end
    join_none

    repeat (3) @(negedge clk);
    #1;
    chk("rst_sync", sync_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_win", dut_win, 0);
    #1 rst = 1'b1;

    // Reference pulse
    sb = sync_tot; bb = busy_tot;
    run_pulses(20, -1, 0);
    chk("ref_syncs", sync_tot - sb, 1);
    chk("ref_latency", sync_cyc - mark_cyc, 1);
    chk("ref_win", dut_win, pack(REFW));
    chk("ref_busy_cycles", busy_tot - bb, 16);
    chk("ref_drop", drop_cnt, 0);

    // Below-threshold pulse
    do_reset();
    sb = sync_tot;
    zeros(20);
    for (int k = 0; k < 11; k++) send(LOWP[k], 0);
    zeros(30);
    idle(3);
    chk("low_syncs", sync_tot - sb, 0);
    chk("low_win", dut_win, 0);

    // Flat top: oldest equal sample wins
    do_reset();
    sb = sync_tot;
    zeros(20);
    send(100, 0); send(2000, 0); send(2000, 0); send(100, 0);
    zeros(30);
    idle(3);
    chk("flat_syncs", sync_tot - sb, 1);
    chk("flat_s4", s4, 100);
    chk("flat_s5", s5, 2000);
    chk("flat_s6", s6, 2000);
    chk("flat_s7", s7, 100);

    // Peaks 8 apart: second dropped
    do_reset();
    sb = sync_tot;
    run_pulses(20, 28, 0);
    chk("near_syncs", sync_tot - sb, 1);
    chk("near_drop", drop_cnt, 1);

    // Peaks 20 apart: both accepted
    do_reset();
    sb = sync_tot;
    run_pulses(20, 40, 0);
    chk("far_syncs", sync_tot - sb, 2);
    chk("far_drop", drop_cnt, 0);

    // Gapped stream: identical window, same latency from last valid sample
    do_reset();
    sb = sync_tot;
    run_pulses(20, -1, 1);
    chk("gap_syncs", sync_tot - sb, 1);
    chk("gap_latency", sync_cyc - mark_cyc, 1);
    chk("gap_win", dut_win, pack(REFW));

    // Reset during HOLD, then a peak inside the first 10 samples
    do_reset();
    zeros(20);
    for (int k = 0; k < 11; k++) send(REFP[k], 0);
    zeros(3);
    idle(1);
    chk("hold_busy", busy, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("hrst_sync", sync_out, 0);
    chk("hrst_busy", busy, 0);
    chk("hrst_drop", drop_cnt, 0);
    chk("hrst_win", dut_win, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    sb = sync_tot;
    for (int k = 0; k < 7; k++) send(TAILP[k], 0);
    zeros(30);
    idle(3);
    chk("early_syncs", sync_tot - sb, 0);
    chk("early_win", dut_win, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
